// File: rtl/debounce_event_arbiter_pkg.sv
// Shared definitions for the button debouncer and event arbiter:
// event type encodings, arbiter state encoding and a width helper.
package debounce_event_arbiter_pkg;

  localparam logic EVT_RELEASE = 1'b0;
  localparam logic EVT_PRESS   = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // Never returns less than 1 so that a value of 1 still yields a usable vector width.
  function automatic int ceillog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/debounce_event_arbiter_tick_gen.sv
// Free-running sample-rate divider: tick_o is high for one cycle every
// TICK_DIV cycles, on the last count before wrapping.
module debounce_event_arbiter_tick_gen
  import debounce_event_arbiter_pkg::*;
#(
  parameter int TICK_DIV = 5000
) (
  input  logic clk,
  input  logic rst_a_p,
  output logic tick_o
);

  localparam int CNT_W = ceillog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debounce_event_arbiter.sv
// Debounces N_BTN pushbuttons against a shared sample tick and serialises the
// resulting press/release events onto one valid/ready port, round-robin.
module debounce_event_arbiter
  import debounce_event_arbiter_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 5000,
  parameter int STABLE_TICKS = 4,
  localparam int IDX_W       = ceillog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_a_p,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic             evt_press,
  output logic [N_BTN-1:0] evt_overrun,
  input  logic             clr_overrun
);

  localparam int CNT_W = ceillog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BTN - 1);

  logic             tick;
  logic [N_BTN-1:0] level_vec;
  logic [N_BTN-1:0] pend_vec;
  logic [N_BTN-1:0] ptype_vec;
  logic [N_BTN-1:0] ovr_vec;
  logic [N_BTN-1:0] grant;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             press_q, press_d;
  logic             valid_q, valid_d;
  logic             found;
  logic [IDX_W-1:0] sel;

  debounce_event_arbiter_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst_a_p (rst_a_p),
    .tick_o  (tick)
  );

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             pend_q;
    logic             ptype_q;
    logic             ovr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ;
    logic             new_evt;

    assign differ  = (sync_q != level_q);
    assign new_evt = tick && differ && (cnt_q == CNT_LAST);
    assign grant[gi] = (state_q == ST_IDLE) && found && (sel == IDX_W'(gi));

    always_comb begin
      cnt_d = cnt_q;
      if (tick) begin
        if (!differ || (cnt_q == CNT_LAST)) cnt_d = '0;
        else                                cnt_d = cnt_q + 1'b1;
      end
    end

    // A new event coinciding with its own grant keeps pend set: the old one leaves, the new one waits.
    always_ff @(posedge clk or posedge rst_a_p) begin
      if (rst_a_p) begin
        meta_q  <= 1'b0;
        sync_q  <= 1'b0;
        level_q <= 1'b0;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        ptype_q <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        meta_q <= btn_in[gi];
        sync_q <= meta_q;
        cnt_q  <= cnt_d;
        if (new_evt) begin
          level_q <= sync_q;
          ptype_q <= sync_q ? EVT_PRESS : EVT_RELEASE;
        end
        if (new_evt)        pend_q <= 1'b1;
        else if (grant[gi]) pend_q <= 1'b0;
        if (new_evt && pend_q && !grant[gi]) ovr_q <= 1'b1;
        else if (clr_overrun)                ovr_q <= 1'b0;
      end
    end

    assign level_vec[gi] = level_q;
    assign pend_vec[gi]  = pend_q;
    assign ptype_vec[gi] = ptype_q;
    assign ovr_vec[gi]   = ovr_q;
  end

  // First pending button at or after ptr, wrapping explicitly past the last index.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    sel      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_BTN; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_BTN) cand = cand - N_BTN;
      cand_idx = IDX_W'(cand);
      if (!found && pend_vec[cand_idx]) begin
        found = 1'b1;
        sel   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    press_d = press_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          idx_d   = sel;
          press_d = ptype_vec[sel];
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      press_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      press_q <= press_d;
      valid_q <= valid_d;
    end
  end

  assign btn_level   = level_vec;
  assign evt_valid   = valid_q;
  assign evt_idx     = idx_q;
  assign evt_press   = press_q;
  assign evt_overrun = ovr_vec;

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// Directed bench for debounce_event_arbiter with TICK_DIV=4, STABLE_TICKS=3, N_BTN=4.
// Edge numbers count rising edges since reset release; the first tick edge is 4.
module tb_debounce_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_a_p = 1'b1;
  logic [3:0] btn_in = 4'b0;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_idx;
  logic       evt_press;
  logic [3:0] evt_overrun;
  logic       clr_overrun = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  debounce_event_arbiter #(
    .N_BTN        (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk         (clk),
    .rst_a_p     (rst_a_p),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_idx     (evt_idx),
    .evt_press   (evt_press),
    .evt_overrun (evt_overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_a_p     = 1'b1;
    btn_in      = 4'b0;
    evt_ready   = 1'b0;
    clr_overrun = 1'b0;
    step(3);
    rst_a_p = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    logic        exp_tick;
    do_reset();
    outs = {btn_level, evt_valid, evt_idx, evt_press, evt_overrun};
    n_cmp++;
    if (outs !== 12'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 000", outs);
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      outs = {btn_level, evt_valid, evt_idx, evt_press, evt_overrun};
      n_cmp++;
      if (outs !== 12'h0) begin
        n_err++;
        $display("FAIL idle_outputs: edge %0d got %h expected 000", cyc, outs);
      end
      exp_tick = ((cyc % 4) == 3);
      n_cmp++;
      if (dut.u_tick_gen.tick_o !== exp_tick) begin
        n_err++;
        $display("FAIL tick_period: edge %0d got %b expected %b", cyc, dut.u_tick_gen.tick_o, exp_tick);
      end
    end
    $display("test_reset done: edge %0d", cyc);
  endtask

  task automatic test_press_hold();
    do_reset();
    btn_in[2] = 1'b1;
    wait_edge(11);
    n_cmp++;
    if (btn_level !== 4'b0000) begin
      n_err++;
      $display("FAIL press_level_early: got %b expected 0000", btn_level);
    end
    step(1);
    n_cmp++;
    if (btn_level !== 4'b0100 || evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL press_level: got level=%b valid=%b expected level=0100 valid=0", btn_level, evt_valid);
    end
    step(1);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd2 || evt_press !== 1'b1) begin
      n_err++;
      $display("FAIL press_event: got v=%b idx=%0d p=%b expected v=1 idx=2 p=1", evt_valid, evt_idx, evt_press);
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_idx !== 2'd2 || evt_press !== 1'b1 || evt_overrun !== 4'b0) begin
        n_err++;
        $display("FAIL hold_stable: edge %0d got v=%b idx=%0d p=%b ovr=%b expected v=1 idx=2 p=1 ovr=0000",
                 cyc, evt_valid, evt_idx, evt_press, evt_overrun);
      end
    end
    evt_ready = 1'b1;
    step(1);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL handshake_drop: got v=%b expected 0", evt_valid);
    end
    $display("test_press_hold done: edge %0d", cyc);
  endtask

  task automatic test_glitch();
    do_reset();
    btn_in[0] = 1'b1;
    step(6);
    btn_in[0] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      n_cmp++;
      if (btn_level !== 4'b0 || evt_valid !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_reject: edge %0d got level=%b v=%b expected level=0000 v=0", cyc, btn_level, evt_valid);
      end
    end
    $display("test_glitch done: edge %0d", cyc);
  endtask

  task automatic test_round_robin();
    int       exp_edge  [6] = '{13, 15, 29, 31, 45, 47};
    int       exp_idx   [6] = '{1, 3, 1, 3, 0, 3};
    logic     exp_press [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    evt_ready = 1'b1;
    btn_in    = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        wait_edge(16);
        btn_in = 4'b0000;
      end
      if (k == 4) begin
        wait_edge(32);
        btn_in = 4'b1001;
      end
      wait_edge(exp_edge[k] - 1);
      n_cmp++;
      if (evt_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rr_gap: edge %0d got v=%b expected 0", cyc, evt_valid);
      end
      step(1);
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_idx !== exp_idx[k][1:0] || evt_press !== exp_press[k]) begin
        n_err++;
        $display("FAIL rr_event%0d: edge %0d got v=%b idx=%0d p=%b expected v=1 idx=%0d p=%b",
                 k, cyc, evt_valid, evt_idx, evt_press, exp_idx[k], exp_press[k]);
      end
      step(1);
      n_cmp++;
      if (evt_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rr_drop%0d: edge %0d got v=%b expected 0", k, cyc, evt_valid);
      end
    end
    $display("test_round_robin done: edge %0d", cyc);
  endtask

  task automatic test_overrun();
    do_reset();
    btn_in[2] = 1'b1;
    wait_edge(13);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd2 || evt_press !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_first: got v=%b idx=%0d p=%b expected v=1 idx=2 p=1", evt_valid, evt_idx, evt_press);
    end
    btn_in[2] = 1'b0;
    wait_edge(24);
    n_cmp++;
    if (btn_level !== 4'b0000 || evt_overrun !== 4'b0000 || evt_press !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_release: got level=%b ovr=%b p=%b expected level=0000 ovr=0000 p=1",
               btn_level, evt_overrun, evt_press);
    end
    btn_in[2] = 1'b1;
    wait_edge(35);
    n_cmp++;
    if (evt_overrun !== 4'b0000) begin
      n_err++;
      $display("FAIL ovr_early: got %b expected 0000", evt_overrun);
    end
    step(1);
    n_cmp++;
    if (evt_overrun !== 4'b0100 || btn_level !== 4'b0100) begin
      n_err++;
      $display("FAIL ovr_set: got ovr=%b level=%b expected ovr=0100 level=0100", evt_overrun, btn_level);
    end
    step(1);
    evt_ready = 1'b1;
    step(1);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_drop1: got v=%b expected 0", evt_valid);
    end
    step(1);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd2 || evt_press !== 1'b1 || evt_overrun !== 4'b0100) begin
      n_err++;
      $display("FAIL ovr_second: got v=%b idx=%0d p=%b ovr=%b expected v=1 idx=2 p=1 ovr=0100",
               evt_valid, evt_idx, evt_press, evt_overrun);
    end
    step(1);
    n_cmp++;
    if (evt_valid !== 1'b0 || evt_overrun !== 4'b0100) begin
      n_err++;
      $display("FAIL ovr_drop2: got v=%b ovr=%b expected v=0 ovr=0100", evt_valid, evt_overrun);
    end
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    n_cmp++;
    if (evt_overrun !== 4'b0000 || evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear: got ovr=%b v=%b expected ovr=0000 v=0", evt_overrun, evt_valid);
    end
    $display("test_overrun done: edge %0d", cyc);
  endtask

  task automatic test_async_reset();
    do_reset();
    btn_in[1] = 1'b1;
    wait_edge(14);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd1 || btn_level !== 4'b0010) begin
      n_err++;
      $display("FAIL ar_before: got v=%b idx=%0d level=%b expected v=1 idx=1 level=0010",
               evt_valid, evt_idx, btn_level);
    end
    @(posedge clk);
    #2;
    rst_a_p = 1'b1;
    #1;
    n_cmp++;
    if (evt_valid !== 1'b0 || btn_level !== 4'b0000) begin
      n_err++;
      $display("FAIL ar_immediate: got v=%b level=%b expected v=0 level=0000", evt_valid, btn_level);
    end
    @(negedge clk);
    rst_a_p = 1'b0;
    wait_edge(11);
    n_cmp++;
    if (btn_level !== 4'b0000 || evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ar_level_early: got level=%b v=%b expected level=0000 v=0", btn_level, evt_valid);
    end
    step(1);
    n_cmp++;
    if (btn_level !== 4'b0010) begin
      n_err++;
      $display("FAIL ar_level: got %b expected 0010", btn_level);
    end
    step(1);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd1 || evt_press !== 1'b1) begin
      n_err++;
      $display("FAIL ar_event: got v=%b idx=%0d p=%b expected v=1 idx=1 p=1", evt_valid, evt_idx, evt_press);
    end
    $display("test_async_reset done: edge %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_press_hold();
    test_glitch();
    test_round_robin();
    test_overrun();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
